// File: rtl/q2_pkg.sv
// q2_pkg -- shared definitions for the Q2 front-panel sequencer.
//   Q2_AW          : Q2 word / address width
//   Q2_DEB_CYCLES  : default switch debounce length in clocks
//   ST_*           : panel FSM state encoding
//   SW_*           : bit index of each panel switch in the raw/event vectors
package q2_pkg;

  localparam int Q2_AW         = 12;
  localparam int Q2_DEB_CYCLES = 16;

  localparam logic [2:0] ST_HALT  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_STEP  = 3'd4;

  localparam int SW_STOP   = 0;
  localparam int SW_LDADDR = 1;
  localparam int SW_DEP    = 2;
  localparam int SW_INCP   = 3;
  localparam int SW_START  = 4;
  localparam int NUM_SW    = 5;

endpackage

// File: rtl/q2_panel_debounce.sv
// q2_panel_debounce -- one panel switch: 2-flop synchronizer, stability
// counter and rising-edge event.
//   clk, rst_n : board clock, async active-low reset
//   i_raw      : raw switch level
//   o_rise     : one-clock pulse when the debounced level goes 0->1
// The event is raised in the same cycle the level register is about to flip,
// so it appears DEB_CYCLES+1 clocks after the raw input rises.
module q2_panel_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  assign w_flip = (r_sync[1] != r_lvl) && (r_cnt == CNT_MAX);
  assign o_rise = w_flip & ~r_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_lvl  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      // any bounce back to the current level restarts the stability window
      if (r_sync[1] == r_lvl) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_lvl <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/q2_panel_ctrl.sv
// q2_panel_ctrl -- Q2 front-panel sequencer.
// Debounces the dep/incp/ldaddr/start/stop switches, owns the memory port
// while the CPU is halted (deposit, address increment, entry-point load) and
// gates the CPU run enable for free-run and single-step.
//   clk, rst_n     : board clock, async active-low reset
//   sw             : data/address switches
//   dep/incp/ldaddr/start/stop : raw panel switches (active-high)
//   cpu_fetch      : CPU instruction-boundary strobe
//   cpu_run        : CPU clock enable
//   pc_load/pc_val : one-cycle PC load request and value
//   pnl_own        : memory mux select (1 = panel port)
//   pnl_addr/pnl_wdata/pnl_we : panel memory write port
// Build option: define PANEL_AUTOINC_EN to post-increment pnl_addr on every
// deposit (the write itself uses the pre-increment address).
module q2_panel_ctrl
  import q2_pkg::*;
#(
  parameter int DEB_CYCLES = Q2_DEB_CYCLES,
  parameter int AW         = Q2_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] sw,
  input  logic          dep,
  input  logic          incp,
  input  logic          ldaddr,
  input  logic          start,
  input  logic          stop,
  input  logic          cpu_fetch,
  output logic          cpu_run,
  output logic          pc_load,
  output logic [AW-1:0] pc_val,
  output logic          pnl_own,
  output logic [AW-1:0] pnl_addr,
  output logic [AW-1:0] pnl_wdata,
  output logic          pnl_we
);

  logic [NUM_SW-1:0] w_raw;
  logic [NUM_SW-1:0] w_rise;
  logic w_ev_stop, w_ev_ld, w_ev_dep, w_ev_inc, w_ev_start;

  logic [2:0]    r_state;
  logic          r_run;
  logic          r_own;
  logic          r_pc_load;
  logic [AW-1:0] r_pc_val;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_wdata;
  logic          r_we;
  logic          r_armed;

  assign w_raw[SW_STOP]   = stop;
  assign w_raw[SW_LDADDR] = ldaddr;
  assign w_raw[SW_DEP]    = dep;
  assign w_raw[SW_INCP]   = incp;
  assign w_raw[SW_START]  = start;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
    q2_panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (w_raw[g]),
      .o_rise (w_rise[g])
    );
  end

  // fixed priority: stop > ldaddr > dep > incp > start; losers are dropped
  assign w_ev_stop  = w_rise[SW_STOP];
  assign w_ev_ld    = w_rise[SW_LDADDR] & ~w_ev_stop;
  assign w_ev_dep   = w_rise[SW_DEP]    & ~w_ev_stop & ~w_rise[SW_LDADDR];
  assign w_ev_inc   = w_rise[SW_INCP]   & ~w_ev_stop & ~w_rise[SW_LDADDR]
                                        & ~w_rise[SW_DEP];
  assign w_ev_start = w_rise[SW_START]  & ~w_ev_stop & ~w_rise[SW_LDADDR]
                                        & ~w_rise[SW_DEP] & ~w_rise[SW_INCP];

  // run and own always switch on the same edge and in opposite directions,
  // so the mux never sees panel ownership while the CPU is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HALT;
      r_run     <= 1'b0;
      r_own     <= 1'b1;
      r_pc_load <= 1'b0;
      r_pc_val  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_pc_load <= 1'b0;
      case (r_state)
        ST_HALT: begin
          if (w_ev_stop) begin
            r_state <= ST_STEP;
            r_run   <= 1'b1;
            r_own   <= 1'b0;
            r_armed <= 1'b0;
          end else if (w_ev_ld) begin
            r_addr    <= sw;
            r_pc_val  <= sw;
            r_pc_load <= 1'b1;
          end else if (w_ev_dep) begin
            r_state <= ST_WR;
            r_wdata <= sw;
            r_we    <= 1'b1;
          end else if (w_ev_inc) begin
            r_addr <= r_addr + AW'(1);
          end else if (w_ev_start) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
            r_own   <= 1'b0;
          end
        end
        ST_WR: begin
          r_we    <= 1'b0;
          r_state <= ST_HALT;
`ifdef PANEL_AUTOINC_EN
          r_addr  <= r_addr + AW'(1);
`endif
        end
        ST_RUN: begin
          if (w_ev_stop) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // the fetch cycle still runs; the CPU halts at the boundary
          if (cpu_fetch) begin
            r_state <= ST_HALT;
            r_run   <= 1'b0;
            r_own   <= 1'b1;
          end
        end
        ST_STEP: begin
          // first boundary starts the instruction, second one ends it
          if (cpu_fetch) begin
            if (r_armed) begin
              r_state <= ST_HALT;
              r_run   <= 1'b0;
              r_own   <= 1'b1;
              r_armed <= 1'b0;
            end else begin
              r_armed <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_HALT;
          r_run   <= 1'b0;
          r_own   <= 1'b1;
          r_we    <= 1'b0;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_run   = r_run;
  assign pc_load   = r_pc_load;
  assign pc_val    = r_pc_val;
  assign pnl_own   = r_own;
  assign pnl_addr  = r_addr;
  assign pnl_wdata = r_wdata;
  assign pnl_we    = r_we;

endmodule

// File: tb/tb_q2_panel_ctrl.sv
// tb_q2_panel_ctrl -- directed bench for q2_panel_ctrl with hand-computed
// expectations. Inputs change on the falling edge; outputs are sampled there.
module tb_q2_panel_ctrl;

  localparam int DEB = 16;
  localparam int AW  = 12;
`ifdef PANEL_AUTOINC_EN
  localparam int AI = 1;
`else
  localparam int AI = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] sw = '0;
  logic          dep = 1'b0, incp = 1'b0, ldaddr = 1'b0, start = 1'b0, stop = 1'b0;
  logic          cpu_fetch = 1'b0;
  logic          cpu_run, pc_load, pnl_own, pnl_we;
  logic [AW-1:0] pc_val, pnl_addr, pnl_wdata;

  q2_panel_ctrl #(.DEB_CYCLES(DEB), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .dep       (dep),
    .incp      (incp),
    .ldaddr    (ldaddr),
    .start     (start),
    .stop      (stop),
    .cpu_fetch (cpu_fetch),
    .cpu_run   (cpu_run),
    .pc_load   (pc_load),
    .pc_val    (pc_val),
    .pnl_own   (pnl_own),
    .pnl_addr  (pnl_addr),
    .pnl_wdata (pnl_wdata),
    .pnl_we    (pnl_we)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int bus_clash = 0;
  int we0;
  logic [AW-1:0] a0;

  always @(negedge clk) begin
    if (pnl_we) we_cnt++;
    if (cpu_run && pnl_own) bus_clash++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // raise one switch and wait until the FSM has acted on its event
  task automatic press(input int which);
    case (which)
      0: stop   = 1'b1;
      1: ldaddr = 1'b1;
      2: dep    = 1'b1;
      3: incp   = 1'b1;
      default: start = 1'b1;
    endcase
    tick(DEB + 2);
  endtask

  task automatic release_sw();
    {stop, ldaddr, dep, incp, start} = '0;
    tick(DEB + 4);
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_run",   cpu_run,   0);
    chk("rst_pcld",  pc_load,   0);
    chk("rst_pcval", pc_val,    0);
    chk("rst_own",   pnl_own,   1);
    chk("rst_addr",  pnl_addr,  0);
    chk("rst_wdata", pnl_wdata, 0);
    chk("rst_we",    pnl_we,    0);
    rst_n = 1'b1;
    tick(2);

    // 1: deposit 0x555 at 0x000, exact latency, single write while held
    sw  = 12'h555;
    we0 = we_cnt;
    dep = 1'b1;
    tick(DEB + 1);
    chk("t1_we_early", pnl_we, 0);
    tick(1);
    chk("t1_we",    pnl_we,    1);
    chk("t1_addr",  pnl_addr,  12'h000);
    chk("t1_wdata", pnl_wdata, 12'h555);
    tick(1);
    chk("t1_we_off", pnl_we, 0);
    tick(30);
    chk("t1_one_wr", we_cnt - we0, 1);
    release_sw();

    // 2: incp then deposit 0xAAA
    press(3);
    chk("t2_inc", pnl_addr, 1 + AI);
    release_sw();
    sw = 12'hAAA;
    press(2);
    chk("t2_we",    pnl_we,    1);
    chk("t2_addr",  pnl_addr,  1 + AI);
    chk("t2_wdata", pnl_wdata, 12'hAAA);
    release_sw();
    chk("t2_addr_after", pnl_addr, 1 + 2 * AI);

    // 3: ldaddr 0xFFF, then incp wraps
    sw = 12'hFFF;
    press(1);
    chk("t3_pcld",  pc_load,  1);
    chk("t3_pcval", pc_val,   12'hFFF);
    chk("t3_addr",  pnl_addr, 12'hFFF);
    chk("t3_run",   cpu_run,  0);
    tick(1);
    chk("t3_pcld_off", pc_load, 0);
    release_sw();
    press(3);
    chk("t3_wrap", pnl_addr, 12'h000);
    release_sw();

    // 4: ldaddr 0x800, single step across two fetch strobes
    sw = 12'h800;
    press(1);
    chk("t4_pcval", pc_val, 12'h800);
    release_sw();
    press(0);
    chk("t4_run", cpu_run, 1);
    chk("t4_own", pnl_own, 0);
    release_sw();
    chk("t4_wait", cpu_run, 1);
    cpu_fetch = 1'b1;
    tick(1);
    cpu_fetch = 1'b0;
    chk("t4_armed", cpu_run, 1);
    tick(5);
    chk("t4_still", cpu_run, 1);
    cpu_fetch = 1'b1;
    chk("t4_fetch2", cpu_run, 1);
    tick(1);
    cpu_fetch = 1'b0;
    chk("t4_halt_run", cpu_run, 0);
    chk("t4_halt_own", pnl_own, 1);
    chk("t4_addr",     pnl_addr, 12'h800);

    // 5: free run, stop drains at next fetch
    press(4);
    chk("t5_run", cpu_run, 1);
    chk("t5_own", pnl_own, 0);
    release_sw();
    tick(10);
    press(0);
    chk("t5_drain", cpu_run, 1);
    release_sw();
    chk("t5_drain_wait", cpu_run, 1);
    cpu_fetch = 1'b1;
    chk("t5_fetch", cpu_run, 1);
    tick(1);
    cpu_fetch = 1'b0;
    chk("t5_halt_run", cpu_run, 0);
    chk("t5_halt_own", pnl_own, 1);
    chk("t5_no_clash", bus_clash, 0);

    // 6: dep+stop together -> step wins, no write
    we0  = we_cnt;
    dep  = 1'b1;
    stop = 1'b1;
    tick(DEB + 2);
    chk("t6_run", cpu_run, 1);
    chk("t6_own", pnl_own, 0);
    chk("t6_we",  pnl_we,  0);
    release_sw();
    chk("t6_no_wr", we_cnt - we0, 0);
    cpu_fetch = 1'b1; tick(1); cpu_fetch = 1'b0; tick(2);
    cpu_fetch = 1'b1; tick(1); cpu_fetch = 1'b0;
    chk("t6_halt", cpu_run, 0);

    // 6b: short glitches produce no event
    a0  = pnl_addr;
    we0 = we_cnt;
    dep = 1'b1;
    tick(DEB - 2);
    dep = 1'b0;
    tick(DEB + 4);
    start = 1'b1;
    tick(DEB - 2);
    start = 1'b0;
    tick(DEB + 4);
    chk("t6_glitch_we",   we_cnt - we0, 0);
    chk("t6_glitch_addr", pnl_addr, a0);
    chk("t6_glitch_run",  cpu_run, 0);

    // reset in the middle of a write
    sw = 12'h123;
    press(2);
    chk("rst_mid_we_pre", pnl_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we",    pnl_we,    0);
    chk("rst_mid_wdata", pnl_wdata, 0);
    chk("rst_mid_own",   pnl_own,   1);
    dep = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
